// File: rtl/noc_traffic_gen.sv
// Wormhole packet traffic generator for one NoC injection port: LFSR payloads, per-VC credits, round-robin VC choice.
// Optional build macro NOC_TG_DEST_SWEEP_EN: destination advances by one (mod N) after every tail.
module noc_traffic_gen #(
  parameter int          WIDTH     = 128,
  parameter int          N         = 16,
  parameter int          NUM_VC    = 2,
  parameter int          BUF_DEPTH = 8,
  parameter int          PKT_LEN   = 4,
  parameter int          NUM_PKTS  = 1000,
  parameter int          DEST_NODE = 15,
  parameter logic [31:0] SEED      = 32'hBAADF00D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_VC-1:0] credit_in,
  output logic [WIDTH-1:0]  flit_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pkt_count,
  output logic [31:0]       stall_count,
  output logic              err_credit_ovf
);

  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int DW  = WIDTH - 3 - VCW - AW;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int IW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int EW  = (DW > 32) ? DW : 32;
  localparam logic [31:0] TAPS = 32'h80200003;

  typedef enum logic [1:0] {IDLE, HEAD, BODY, DONE} state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'd0);
  endfunction

  function automatic logic [WIDTH-1:0] build_flit(input logic hd, input logic tl,
                                                  input logic [VCW-1:0] vc,
                                                  input logic [AW-1:0] dst,
                                                  input logic [31:0] val);
    logic [WIDTH-1:0] f;
    logic [EW-1:0]    ext;
    ext = EW'(val);
    f = '0;
    f[WIDTH-1] = 1'b1;
    f[WIDTH-2] = hd;
    f[WIDTH-3] = tl;
    f[WIDTH-4 -: VCW] = vc;
    f[WIDTH-4-VCW -: AW] = dst;
    f[DW-1:0] = ext[DW-1:0];
    return f;
  endfunction

  state_t         state;
  logic [31:0]    lfsr;
  logic [VCW-1:0] rr;
  logic [VCW-1:0] cur_vc;
  logic [IW-1:0]  flit_idx;
  logic [CW-1:0]  credit [NUM_VC];
  logic [AW-1:0]  dest;

  logic           start_acc;
  logic           found;
  logic [VCW-1:0] pick;
  logic [VCW-1:0] pick_nxt;
  logic [VCW:0]   cand_w;
  logic [VCW-1:0] cand;
  logic           send;
  logic           send_head;
  logic           send_tail;
  logic [VCW-1:0] send_vc;
  logic           last;
  logic           pkt_done;
  logic           run_end;
  logic [NUM_VC-1:0] dec;
  logic [NUM_VC-1:0] ovf;

  assign start_acc = start && (state == IDLE || state == DONE);

  // Round-robin search for the first VC holding credit, starting at rr.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand_w = '0;
    cand   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      cand_w = {1'b0, rr} + (VCW+1)'(i);
      if (cand_w >= (VCW+1)'(NUM_VC))
        cand_w = cand_w - (VCW+1)'(NUM_VC);
      cand = cand_w[VCW-1:0];
      if (!found && credit[cand] != '0) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_nxt = (pick == VCW'(NUM_VC - 1)) ? '0 : pick + 1'b1;
  assign last     = (flit_idx == IW'(PKT_LEN - 1));

  always_comb begin
    send      = 1'b0;
    send_head = 1'b0;
    send_tail = 1'b0;
    send_vc   = cur_vc;
    case (state)
      HEAD: begin
        send      = found;
        send_head = 1'b1;
        send_tail = (PKT_LEN == 1);
        send_vc   = pick;
      end
      BODY: begin
        send      = (credit[cur_vc] != '0);
        send_tail = last;
      end
      default: ;
    endcase
  end

  assign pkt_done = send && send_tail;
  assign run_end  = (pkt_count + 32'd1) == 32'(NUM_PKTS);

  // A send and a return on the same VC cancel; a lone return at full depth is an overflow.
  always_comb begin
    dec = '0;
    ovf = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      dec[v] = send && (send_vc == VCW'(v));
      ovf[v] = credit_in[v] && !dec[v] && (credit[v] == CW'(BUF_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++)
        credit[v] <= CW'(BUF_DEPTH);
      err_credit_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (credit_in[v] && !dec[v] && !ovf[v])
          credit[v] <= credit[v] + 1'b1;
        else if (dec[v] && !credit_in[v])
          credit[v] <= credit[v] - 1'b1;
      end
      err_credit_ovf <= (start_acc ? 1'b0 : err_credit_ovf) | (|ovf);
    end
  end

`ifdef NOC_TG_DEST_SWEEP_EN
  always_ff @(posedge clk) begin
    if (!reset || start_acc)
      dest <= AW'(DEST_NODE);
    else if (pkt_done)
      dest <= (dest == AW'(N - 1)) ? '0 : dest + 1'b1;
  end
`else
  assign dest = AW'(DEST_NODE);
`endif

  // Output stage: flit register, LFSR advance and packet FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_count   <= '0;
      stall_count <= '0;
      flit_out    <= '0;
      lfsr        <= SEED;
      rr          <= '0;
      cur_vc      <= '0;
      flit_idx    <= '0;
    end else begin
      flit_out <= send ? build_flit(send_head, send_tail, send_vc, dest, lfsr) : '0;
      if (send)
        lfsr <= lfsr_next(lfsr);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HEAD;
            busy        <= 1'b1;
            done        <= 1'b0;
            pkt_count   <= '0;
            stall_count <= '0;
            lfsr        <= SEED;
            rr          <= '0;
          end
        end
        HEAD, BODY: begin
          if (!send) begin
            stall_count <= stall_count + 32'd1;
          end else begin
            if (state == HEAD) begin
              cur_vc   <= pick;
              rr       <= pick_nxt;
              flit_idx <= IW'(1);
              if (!pkt_done)
                state <= BODY;
            end else begin
              flit_idx <= flit_idx + 1'b1;
            end
            if (pkt_done) begin
              pkt_count <= pkt_count + 32'd1;
              if (run_end) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= HEAD;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: one instance with credits always returned, one starved of credits.
module tb_noc_traffic_gen;
  localparam int W = 128;
  localparam logic [31:0] SEED = 32'hBAADF00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, start_a, busy_a, done_a, err_a;
  logic [1:0]   ca;
  logic [W-1:0] fo_a;
  logic [31:0]  pc_a, sc_a;

  logic         rst_b, start_b, busy_b, done_b, err_b;
  logic [1:0]   cb;
  logic [W-1:0] fo_b;
  logic [31:0]  pc_b, sc_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] lf;
  logic [3:0]  dexp;

  noc_traffic_gen #(.WIDTH(W), .N(16), .NUM_VC(2), .BUF_DEPTH(8), .PKT_LEN(4),
                    .NUM_PKTS(3), .DEST_NODE(15), .SEED(SEED)) dut (
    .clk(clk), .reset(rst_a), .start(start_a), .credit_in(ca), .flit_out(fo_a),
    .busy(busy_a), .done(done_a), .pkt_count(pc_a), .stall_count(sc_a),
    .err_credit_ovf(err_a));

  noc_traffic_gen #(.WIDTH(W), .N(16), .NUM_VC(2), .BUF_DEPTH(8), .PKT_LEN(4),
                    .NUM_PKTS(10), .DEST_NODE(14), .SEED(SEED)) u_b (
    .clk(clk), .reset(rst_b), .start(start_b), .credit_in(cb), .flit_out(fo_b),
    .busy(busy_b), .done(done_b), .pkt_count(pc_b), .stall_count(sc_b),
    .err_credit_ovf(err_b));

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] t;
    t = x >> 1;
    if (x[0]) t = t ^ 32'h80200003;
    return t;
  endfunction

  // VALID, HEAD, TAIL, VC(1), DEST(4), DATA(120) = zero-extended LFSR value.
  function automatic logic [W-1:0] exp_flit(input logic h, input logic t, input logic vc,
                                            input logic [3:0] dst, input logic [31:0] val);
    return {1'b1, h, t, vc, dst, 88'd0, val};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b0; start_a = 1'b0; ca = 2'b00;
    rst_b = 1'b0; start_b = 1'b0; cb = 2'b00;
    step;
    step;
    check("rst flit", fo_a, '0);
    check("rst busy", W'(busy_a), '0);
    check("rst done", W'(done_a), '0);
    check("rst pkt", W'(pc_a), '0);
    check("rst stall", W'(sc_a), '0);
    check("rst err", W'(err_a), '0);
    check("rst cred0", W'(dut.credit[0]), W'(8));
    check("rst cred1", W'(u_b.credit[1]), W'(8));

    // Full-credit run: 3 packets x 4 flits, back to back.
    rst_a = 1'b1;
    step;
    start_a = 1'b1; ca = 2'b11;
    step;
    start_a = 1'b0;
    check("t1 busy", W'(busy_a), W'(1));
    check("t1 first idle", fo_a, '0);
    lf = SEED;
    for (int f = 0; f < 12; f++) begin
      step;
      check($sformatf("t1 flit%0d", f), fo_a,
            exp_flit(f % 4 == 0, f % 4 == 3, 1'((f / 4) % 2), 4'd15, lf));
      lf = lfsr_step(lf);
    end
    check("t1 done", W'(done_a), W'(1));
    check("t1 busy end", W'(busy_a), '0);
    check("t1 pkt", W'(pc_a), W'(3));
    check("t1 stall", W'(sc_a), '0);
    step;
    check("t1 idle", fo_a, '0);
    ca = 2'b00;

    // Credit return into a full VC right after reset.
    rst_b = 1'b1; cb = 2'b10;
    step;
    cb = 2'b00;
    check("ovf err", W'(err_b), W'(1));
    check("ovf cred1", W'(u_b.credit[1]), W'(8));
    step;
    check("ovf sticky", W'(err_b), W'(1));

    // Start clears the error; head send coincides with a VC0 return.
    start_b = 1'b1;
    step;
    start_b = 1'b0; cb = 2'b01;
    check("b busy", W'(busy_b), W'(1));
    check("b err clr", W'(err_b), '0);
    step;
    cb = 2'b00;
    check("same head", fo_b, exp_flit(1'b1, 1'b0, 1'b0, 4'd14, SEED));
    check("same cred0", W'(u_b.credit[0]), W'(8));
    check("same err", W'(err_b), '0);
    step;
    check("mid flit1", fo_b, exp_flit(1'b0, 1'b0, 1'b0, 4'd14, lfsr_step(SEED)));
    check("mid cred0", W'(u_b.credit[0]), W'(7));

    // Reset lands on the edge that would carry flit 2.
    rst_b = 1'b0;
    step;
    check("mr flit", fo_b, '0);
    check("mr busy", W'(busy_b), '0);
    check("mr cred0", W'(u_b.credit[0]), W'(8));
    check("mr cred1", W'(u_b.credit[1]), W'(8));
    check("mr pkt", W'(pc_b), '0);

    // Starved run: 16 flits drain both VCs, then stalls.
    rst_b = 1'b1;
    step;
    start_b = 1'b1;
    step;
    start_b = 1'b0;
    lf = SEED;
    for (int f = 0; f < 16; f++) begin
      step;
`ifdef NOC_TG_DEST_SWEEP_EN
      dexp = 4'(14 + f / 4);
`else
      dexp = 4'd14;
`endif
      check($sformatf("t2 flit%0d", f), fo_b,
            exp_flit(f % 4 == 0, f % 4 == 3, 1'((f / 4) % 2), dexp, lf));
      lf = lfsr_step(lf);
    end
    check("t2 pkt", W'(pc_b), W'(4));
    check("t2 stall0", W'(sc_b), '0);
    check("t2 cred0", W'(u_b.credit[0]), '0);
    check("t2 cred1", W'(u_b.credit[1]), '0);
    for (int i = 0; i < 3; i++) begin
      step;
      check($sformatf("t2 stall flit%0d", i), fo_b, '0);
      check($sformatf("t2 stall%0d", i), W'(sc_b), W'(i + 1));
    end
    cb = 2'b01;
    step;
    cb = 2'b00;
    check("rel wait flit", fo_b, '0);
    check("rel wait stall", W'(sc_b), W'(4));
    step;
`ifdef NOC_TG_DEST_SWEEP_EN
    dexp = 4'd2;
`else
    dexp = 4'd14;
`endif
    check("rel head", fo_b, exp_flit(1'b1, 1'b0, 1'b0, dexp, lf));
    step;
    check("rel after flit", fo_b, '0);
    check("rel after stall", W'(sc_b), W'(5));
    check("rel cred0", W'(u_b.credit[0]), '0);
    check("rel busy", W'(busy_b), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
